// File: rtl/vc_reset_seq.sv
// vc_reset_seq: reset / bring-up sequencer for the vc CPU top level.
//
// rst_n and ena are sampled through a SYNC_STAGES-deep pipeline. The pipe output
// forms the internal reset. When the internal reset releases, cpu_reset is held
// for STRETCH more cycles. A first bring-up (cause 0) then spends one cycle
// capturing the boot strap from ui_in before entering RUN. In RUN a soft-reset
// request (or, when enabled, a watchdog expiry) re-runs the stretch. This re-run
// skips the strap capture and keeps the strap captured earlier.
//
// Optional feature: define VC_RST_WATCHDOG_EN to build the RUN-state watchdog.
// When it is defined, wdt_kick restarts the watchdog. When it is not defined,
// there is no counter, wdt_kick is ignored and rst_cause never reads 3.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset, sampled on posedge clk
//   ena          in   design enable; low is treated as reset
//   ui_in        in   [STRAP_W] strap source, sampled once in STRAP
//   soft_rst_req in   CPU soft-reset request (level), honoured in RUN only
//   wdt_kick     in   watchdog restart pulse (watchdog build only)
//   cpu_reset    out  active-high reset to the CPU core
//   io_safe      out  1 = top forces uio_oe to 8'h00
//   strap        out  [STRAP_W] latched boot-strap value
//   state        out  [2] 0 HOLD, 1 STRETCH, 2 STRAP, 3 RUN
//   rst_cause    out  [2] 0 external/ena, 2 soft, 3 watchdog
module vc_reset_seq #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 16,
   parameter int unsigned STRAP_W     = 4,
   parameter int unsigned WDT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [STRAP_W-1:0] ui_in,
   input  logic               soft_rst_req,
   input  logic               wdt_kick,
   output logic               cpu_reset,
   output logic               io_safe,
   output logic [STRAP_W-1:0] strap,
   output logic [1:0]         state,
   output logic [1:0]         rst_cause
);

   localparam int unsigned STRETCH_EFF = (STRETCH == 0) ? 1 : STRETCH;
   localparam int unsigned CNT_W       = $clog2(STRETCH_EFF) + 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_STRAP   = 2'd2,
      ST_RUN     = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_EXT  = 2'd0;
   localparam logic [1:0] CAUSE_SOFT = 2'd2;

   logic [SYNC_STAGES-1:0] rst_pipe_q;
   logic [SYNC_STAGES-1:0] ena_pipe_q;
   logic                   int_rst;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           cause_q, cause_d;
   logic [STRAP_W-1:0]   strap_q, strap_d;
   logic                 cpu_reset_q, cpu_reset_d;

   // Sample pipeline: a low rst_n shifts a 0 into both pipes, so a reset
   // reaches the sequencer after the same SYNC_STAGES delay as a release.
   always_ff @(posedge clk) begin
      rst_pipe_q[0] <= rst_n;
      ena_pipe_q[0] <= ena & rst_n;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         rst_pipe_q[i] <= rst_pipe_q[i-1];
         ena_pipe_q[i] <= ena_pipe_q[i-1];
      end
   end

   assign int_rst = ~rst_pipe_q[SYNC_STAGES-1] | ~ena_pipe_q[SYNC_STAGES-1];

`ifdef VC_RST_WATCHDOG_EN
   localparam logic [1:0] CAUSE_WDT = 2'd3;
   logic [WDT_W-1:0] wdt_q, wdt_d;
`else
   logic unused_wdt_kick;
   assign unused_wdt_kick = wdt_kick;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      strap_d = strap_q;
`ifdef VC_RST_WATCHDOG_EN
      wdt_d   = '0;
`endif

      unique case (state_q)
         ST_HOLD: begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
         end
         ST_STRETCH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STRETCH_EFF - 1)) begin
               // Re-resets skip strap capture and keep the earlier strap
               state_d = (cause_q == CAUSE_EXT) ? ST_STRAP : ST_RUN;
            end
         end
         ST_STRAP: begin
            strap_d = ui_in;
            state_d = ST_RUN;
         end
         ST_RUN: begin
`ifdef VC_RST_WATCHDOG_EN
            // Kick beats expiry; expiry beats soft request
            if (wdt_kick) begin
               wdt_d = '0;
            end else if (wdt_q == '1) begin
               wdt_d = '0;
            end else begin
               wdt_d = wdt_q + WDT_W'(1);
            end
            if (!wdt_kick && wdt_q == '1) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
               cause_d = CAUSE_WDT;
            end else if (soft_rst_req) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
               cause_d = CAUSE_SOFT;
               wdt_d   = '0;
            end
`else
            if (soft_rst_req) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
               cause_d = CAUSE_SOFT;
            end
`endif
         end
      endcase

      if (int_rst) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         cause_d = CAUSE_EXT;
         strap_d = '0;
`ifdef VC_RST_WATCHDOG_EN
         wdt_d   = '0;
`endif
      end

      cpu_reset_d = (state_d != ST_RUN);
   end

   // Sequencer registers
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      strap_q     <= strap_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef VC_RST_WATCHDOG_EN
      wdt_q       <= wdt_d;
`endif
   end

   assign cpu_reset = cpu_reset_q;
   assign io_safe   = cpu_reset_q;
   assign strap     = strap_q;
   assign state     = state_q;
   assign rst_cause = cause_q;

endmodule
